rv_mem_resp: RTL and testbench

RV_MEM_RESP -- requirements
Module: rv_mem_resp

---
 rtl/rv_mem_pkg.sv | 18 +
 rtl/rv_mem_array.sv | 21 ++
 rtl/rv_mem_resp.sv | 104 ++++++++++
 tb/tb_rv_mem_resp.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the wait-stated word memory responder.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Word-aligned and inside the storage window.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] == 2'b00) && (a < 32'(depth * 4));
  endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Word storage: combinational read, synchronous write. Never cleared by reset.
module rv_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rv_mem_resp.sv
// Single-outstanding memory responder: capture request, wait WAIT_CYCLES, pulse ready.
module rv_mem_resp
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memrw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic        rw_q;
  logic        ready_q, busy_q, err_q;
  logic [31:0] rdata_q;

  logic [31:0] acc_addr;
  logic        acc_rw, acc_ok, we;
  logic [31:0] mem_rdata, resp_rdata;

  // In IDLE the live inputs describe the access (needed when WAIT_CYCLES=0).
  assign acc_addr   = (state_q == ST_IDLE) ? addr  : addr_q;
  assign acc_rw     = (state_q == ST_IDLE) ? memrw : rw_q;
  assign acc_ok     = addr_ok(acc_addr, DEPTH_WORDS);
  assign resp_rdata = (acc_ok && acc_rw == MEM_READ) ? mem_rdata : 32'h0;
  assign we         = (state_q == ST_RESP) && (rw_q == MEM_WRITE) && acc_ok;

  rv_mem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rw_q    <= MEM_READ;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            rw_q    <= memrw;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= ~acc_ok;
              rdata_q <= resp_rdata;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= ~acc_ok;
            rdata_q <= resp_rdata;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Randomized bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_rv_mem_resp;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        req_s   [2];
  logic        rw_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        busy_s  [2];
  logic        err_s   [2];

  logic [31:0] mdl [2][256];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .memrw(rw_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  rv_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .memrw(rw_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One access on instance u; called at a negedge, returns at the negedge after ready
  // plus one idle cycle. Latency counts negedges from the capture edge to ready.
  task automatic access(input int u, input logic rw, input logic [31:0] a, input logic [31:0] d);
    logic        bad;
    logic [31:0] exp_rd;
    int          lat_exp;
    bit          got;
    bad     = (a[1:0] != 2'b00) || (a >= 32'd1024);
    exp_rd  = (!bad && rw == 1'b0) ? mdl[u][a[9:2]] : 32'h0;
    lat_exp = (u == 0) ? 3 : 1;
    req_s[u] = 1'b1; rw_s[u] = rw; addr_s[u] = a; wdata_s[u] = d;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      req_s[u] = 1'b0;
      if (ready_s[u]) begin
        got = 1'b1;
        chk("latency", 64'(n), 64'(lat_exp));
        chk("err", 64'(err_s[u]), 64'(bad));
        chk("rdata", 64'(rdata_s[u]), 64'(exp_rd));
      end else begin
        chk("busy_wait", 64'(busy_s[u]), 64'd1);
      end
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    if (!bad && rw) mdl[u][a[9:2]] = d;
    @(negedge clk);
    chk("idle_after", 64'({ready_s[u], busy_s[u], err_s[u], rdata_s[u]}), 64'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b0; req_s[u] = 1'b0; rw_s[u] = 1'b0; addr_s[u] = 32'h0; wdata_s[u] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk("reset_out0", 64'({ready_s[0], busy_s[0], err_s[0], rdata_s[0]}), 64'd0);
    chk("reset_out1", 64'({ready_s[1], busy_s[1], err_s[1], rdata_s[1]}), 64'd0);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    @(negedge clk);

    // Fill every word so reads always have a defined expectation.
    for (int w = 0; w < 256; w++) access(0, 1'b1, 32'(w * 4), $urandom);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b0, 32'h12, 32'h0);
    access(0, 1'b0, 32'h400, 32'h0);
    access(0, 1'b1, 32'h13, 32'h55555555);
    access(0, 1'b1, 32'h404, 32'h66666666);
    access(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b0, 32'h3FC, 32'h0);
    access(0, 1'b1, 32'h40, 32'h1);
    access(0, 1'b0, 32'h40, 32'h0);

    // Held request: one completion every 4 cycles, one idle cycle between.
    req_s[0] = 1'b1; rw_s[0] = 1'b0; addr_s[0] = 32'h10;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 12) req_s[0] = 1'b0;
      chk("held_ready", 64'(ready_s[0]), 64'(n % 4 == 3));
      chk("held_busy", 64'(busy_s[0]), 64'(n % 4 != 0));
      if (ready_s[0]) chk("held_rdata", 64'(rdata_s[0]), 64'(mdl[0][4]));
    end
    @(negedge clk);

    // Reset in WAIT aborts the write.
    req_s[0] = 1'b1; rw_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h12345678;
    @(negedge clk);
    req_s[0] = 1'b0;
    chk("pre_rst_busy", 64'(busy_s[0]), 64'd1);
    rst_s[0] = 1'b0;
    #1;
    chk("rst_async_out", 64'({ready_s[0], busy_s[0], err_s[0], rdata_s[0]}), 64'd0);
    @(negedge clk);
    rst_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_resume", 64'({ready_s[0], busy_s[0]}), 64'd0);
    access(0, 1'b0, 32'h20, 32'h0);

    // Zero-wait build.
    access(1, 1'b1, 32'h3FC, 32'hA5A5A5A5);
    access(1, 1'b0, 32'h3FC, 32'h0);
    access(1, 1'b0, 32'h3FE, 32'h0);
    access(1, 1'b1, 32'h0, 32'h0BADF00D);
    access(1, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 1) a = $urandom | 32'h400;
      else                a = 32'($urandom_range(0, 255)) << 2;
      d = $urandom;
      access(0, 1'($urandom_range(0, 1)), a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
